// File: rtl/scpad_req_arbiter_pkg.sv
// Shared scratchpad request types, widths and arbiter defaults.
package scpad_req_arbiter_pkg;

  localparam int ROW_IDX_WIDTH         = 8;
  localparam int SCPAD_NUM_COLS        = 4;
  localparam int SCPAD_COL_W           = 8;
  localparam int MAX_SRAM_DELAY        = 3;
  localparam int SCPAD_MAX_OUTSTANDING = MAX_SRAM_DELAY + 1;
  localparam int SCPAD_STARVE_LIMIT    = 8;

  typedef logic [SCPAD_NUM_COLS-1:0]             mask_t;
  typedef logic [SCPAD_NUM_COLS*SCPAD_COL_W-1:0] scpad_data_t;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  typedef struct packed {
    logic                     write;
    logic [ROW_IDX_WIDTH-1:0] row;
    mask_t                    mask;
    scpad_data_t              wdata;
  } scpad_req_t;

endpackage

// File: rtl/scpad_req_arbiter_src_fifo.sv
// In-order FIFO of read-request sources; one entry per read in flight.
module scpad_src_fifo
  import scpad_req_arbiter_pkg::*;
#(
  parameter int DEPTH = SCPAD_MAX_OUTSTANDING,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  src_t             i_push_src,
  input  logic             i_pop,
  output src_t             o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  src_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so non-power-of-2 depths stay inside the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_src;
  end

endmodule

// File: rtl/scpad_req_arbiter.sv
// FE/BE arbiter for one scratchpad SRAM-controller port with aging,
// stall lock, and in-order read-response steering.
module scpad_req_arbiter
  import scpad_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = SCPAD_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = SCPAD_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fe_req_valid,
  output logic                     fe_req_ready,
  input  logic                     fe_req_write,
  input  logic [ROW_IDX_WIDTH-1:0] fe_req_row,
  input  mask_t                    fe_req_mask,
  input  scpad_data_t              fe_req_wdata,
  input  logic                     be_req_valid,
  output logic                     be_req_ready,
  input  logic                     be_req_write,
  input  logic [ROW_IDX_WIDTH-1:0] be_req_row,
  input  mask_t                    be_req_mask,
  input  scpad_data_t              be_req_wdata,
  output logic                     sram_req_valid,
  input  logic                     sram_req_ready,
  output logic                     sram_req_write,
  output logic [ROW_IDX_WIDTH-1:0] sram_req_row,
  output mask_t                    sram_req_mask,
  output scpad_data_t              sram_req_wdata,
  input  logic                     sram_rsp_valid,
  input  scpad_data_t              sram_rsp_rdata,
  output logic                     fe_rsp_valid,
  output scpad_data_t              fe_rsp_rdata,
  output logic                     be_rsp_valid,
  output scpad_data_t              be_rsp_rdata,
  output logic                     rsp_err
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             r_lock;
  src_t             r_lock_src;
  scpad_req_t       r_lock_req;
  logic [AGE_W-1:0] r_age;
  logic             r_rsp_err;

  scpad_req_t       w_fe_req;
  scpad_req_t       w_be_req;
  scpad_req_t       w_grant_req;
  src_t             w_grant_src;
  logic             w_grant_valid;
  logic             w_fe_elig;
  logic             w_be_elig;
  logic             w_starved;
  logic             w_hs;
  logic             w_be_hs;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  src_t             w_head;

  assign w_fe_req  = {fe_req_write, fe_req_row, fe_req_mask, fe_req_wdata};
  assign w_be_req  = {be_req_write, be_req_row, be_req_mask, be_req_wdata};
  // Reads are held off while every response slot is already spoken for.
  assign w_fe_elig = fe_req_valid && (fe_req_write || !w_fifo_full);
  assign w_be_elig = be_req_valid && (be_req_write || !w_fifo_full);
  assign w_starved = (r_age >= AGE_W'(STARVE_LIMIT));

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_src   = SRC_FE;
    w_grant_req   = w_fe_req;
    if (rst) begin
      w_grant_valid = 1'b0;
    end else if (r_lock) begin
      w_grant_valid = 1'b1;
      w_grant_src   = r_lock_src;
      w_grant_req   = r_lock_req;
    end else if (w_be_elig && (!w_fe_elig || w_starved)) begin
      w_grant_valid = 1'b1;
      w_grant_src   = SRC_BE;
      w_grant_req   = w_be_req;
    end else if (w_fe_elig) begin
      w_grant_valid = 1'b1;
    end
  end

  assign sram_req_valid = w_grant_valid;
  assign sram_req_write = w_grant_req.write;
  assign sram_req_row   = w_grant_req.row;
  assign sram_req_mask  = w_grant_req.mask;
  assign sram_req_wdata = w_grant_req.wdata;

  assign w_hs         = w_grant_valid && sram_req_ready;
  assign w_be_hs      = w_hs && (w_grant_src == SRC_BE);
  assign fe_req_ready = w_hs && (w_grant_src == SRC_FE);
  assign be_req_ready = w_be_hs;
  assign w_push       = w_hs && !w_grant_req.write;
  assign w_pop        = sram_rsp_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_FE;
      r_age      <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_lock <= w_grant_valid && !sram_req_ready;
      if (w_grant_valid) r_lock_src <= w_grant_src;
      if (!be_req_valid || w_be_hs) r_age <= '0;
      else if (!w_starved)          r_age <= r_age + 1'b1;
      if (sram_rsp_valid && w_fifo_empty) r_rsp_err <= 1'b1;
    end
  end

  // Stalled request fields are captured so the SRAM side sees them frozen.
  always_ff @(posedge clk) begin
    if (w_grant_valid && !sram_req_ready) r_lock_req <= w_grant_req;
  end

  scpad_src_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_src(w_grant_src),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign fe_rsp_valid = w_pop && (w_fifo_count != '0) && (w_head == SRC_FE);
  assign be_rsp_valid = w_pop && (w_fifo_count != '0) && (w_head == SRC_BE);
  assign fe_rsp_rdata = sram_rsp_rdata;
  assign be_rsp_rdata = sram_rsp_rdata;
  assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Directed table-driven bench for scpad_req_arbiter plus its source FIFO.
module tb_scpad_req_arbiter;
  import scpad_req_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic fe_req_valid, fe_req_ready, fe_req_write;
  logic [ROW_IDX_WIDTH-1:0] fe_req_row;
  mask_t fe_req_mask;
  scpad_data_t fe_req_wdata;
  logic be_req_valid, be_req_ready, be_req_write;
  logic [ROW_IDX_WIDTH-1:0] be_req_row;
  mask_t be_req_mask;
  scpad_data_t be_req_wdata;
  logic sram_req_valid, sram_req_ready, sram_req_write;
  logic [ROW_IDX_WIDTH-1:0] sram_req_row;
  mask_t sram_req_mask;
  scpad_data_t sram_req_wdata;
  logic sram_rsp_valid;
  scpad_data_t sram_rsp_rdata;
  logic fe_rsp_valid, be_rsp_valid, rsp_err;
  scpad_data_t fe_rsp_rdata, be_rsp_rdata;

  logic f_rst, f_push, f_pop, f_full, f_empty;
  src_t f_src, f_head;
  logic [2:0] f_count;

  int n_checks = 0;
  int n_err    = 0;

  scpad_req_arbiter dut (
    .clk(clk), .rst(rst),
    .fe_req_valid(fe_req_valid), .fe_req_ready(fe_req_ready), .fe_req_write(fe_req_write),
    .fe_req_row(fe_req_row), .fe_req_mask(fe_req_mask), .fe_req_wdata(fe_req_wdata),
    .be_req_valid(be_req_valid), .be_req_ready(be_req_ready), .be_req_write(be_req_write),
    .be_req_row(be_req_row), .be_req_mask(be_req_mask), .be_req_wdata(be_req_wdata),
    .sram_req_valid(sram_req_valid), .sram_req_ready(sram_req_ready),
    .sram_req_write(sram_req_write), .sram_req_row(sram_req_row),
    .sram_req_mask(sram_req_mask), .sram_req_wdata(sram_req_wdata),
    .sram_rsp_valid(sram_rsp_valid), .sram_rsp_rdata(sram_rsp_rdata),
    .fe_rsp_valid(fe_rsp_valid), .fe_rsp_rdata(fe_rsp_rdata),
    .be_rsp_valid(be_rsp_valid), .be_rsp_rdata(be_rsp_rdata),
    .rsp_err(rsp_err)
  );

  scpad_src_fifo #(.DEPTH(4)) u_fifo (
    .clk(clk), .rst(f_rst), .i_push(f_push), .i_push_src(f_src), .i_pop(f_pop),
    .o_head(f_head), .o_full(f_full), .o_empty(f_empty), .o_count(f_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic        fv, fw;
    logic [7:0]  frow;
    logic        bv, bw;
    logic [7:0]  brow;
    logic        srdy, rv;
    logic [31:0] rd;
    logic        esv, ewr;
    logic [7:0]  erow;
    logic [4:0]  ef;   // {fe_ready, be_ready, fe_rsp, be_rsp, rsp_err}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic r,
                     input logic fv, input logic fw, input logic [7:0] frow,
                     input logic bv, input logic bw, input logic [7:0] brow,
                     input logic srdy, input logic rv, input logic [31:0] rd,
                     input logic esv, input logic ewr, input logic [7:0] erow,
                     input logic [4:0] ef);
    vec_t v;
    v.tag = tag; v.rst = r; v.fv = fv; v.fw = fw; v.frow = frow;
    v.bv = bv; v.bw = bw; v.brow = brow; v.srdy = srdy; v.rv = rv; v.rd = rd;
    v.esv = esv; v.ewr = ewr; v.erow = erow; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic fv, input logic fw, input logic [7:0] frow,
                       input logic bv, input logic bw, input logic [7:0] brow,
                       input logic srdy, input logic rv, input logic [31:0] rd);
    rst = r;
    fe_req_valid = fv; fe_req_write = fw; fe_req_row = frow;
    fe_req_mask = frow[3:0] ^ 4'hF; fe_req_wdata = {4{frow}};
    be_req_valid = bv; be_req_write = bw; be_req_row = brow;
    be_req_mask = brow[3:0] ^ 4'hF; be_req_wdata = {4{brow}};
    sram_req_ready = srdy; sram_rsp_valid = rv; sram_rsp_rdata = rd;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle_cycle(input logic r, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    drive(r, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, rv, rd);
    #1;
  endtask

  initial begin
    logic [63:0] got, exp;
    src_t pop_exp [4];

    // Starvation: FE wins 8 cycles, BE forced on the 9th, then FE again.
    add("rst", 1, 1,0,8'h10, 1,0,8'h80, 1, 1,32'h0, 0,0,8'h00, 5'b00000);
    add("starve_c1", 0, 1,0,8'h10, 1,0,8'h80, 1, 0,32'h0, 1,0,8'h10, 5'b10000);
    for (int k = 2; k <= 8; k++)
      add($sformatf("starve_c%0d", k), 0, 1,0,8'h10, 1,0,8'h80, 1, 1,32'hD000_0000 + k,
          1,0,8'h10, 5'b10100);
    add("starve_c9", 0, 1,0,8'h10, 1,0,8'h80, 1, 1,32'hD000_0009, 1,0,8'h80, 5'b01100);
    add("starve_c10", 0, 1,0,8'h10, 1,0,8'h80, 1, 1,32'hD000_000A, 1,0,8'h10, 5'b10010);
    add("starve_drain", 0, 0,0,8'h00, 0,0,8'h00, 1, 1,32'hD000_000B, 0,0,8'h00, 5'b00100);
    // Stall lock: FE held 3 stall cycles, then BE write.
    for (int k = 1; k <= 3; k++)
      add($sformatf("lock_stall%0d", k), 0, 1,0,8'h21, 1,1,8'h91, 0, 0,32'h0, 1,0,8'h21, 5'b00000);
    add("lock_hs", 0, 1,0,8'h21, 1,1,8'h91, 1, 0,32'h0, 1,0,8'h21, 5'b10000);
    add("lock_be", 0, 0,0,8'h00, 1,1,8'h91, 1, 1,32'hA5A5_0001, 1,1,8'h91, 5'b01100);
    // Long stall: BE reaches the starve limit but cannot preempt a locked FE.
    for (int k = 1; k <= 10; k++)
      add($sformatf("lock_long%0d", k), 0, 1,0,8'h22, 1,1,8'h92, 0, 0,32'h0, 1,0,8'h22, 5'b00000);
    add("lock_long_hs", 0, 1,0,8'h22, 1,1,8'h92, 1, 0,32'h0, 1,0,8'h22, 5'b10000);
    add("lock_long_be", 0, 1,0,8'h22, 1,1,8'h92, 1, 1,32'hA5A5_0002, 1,1,8'h92, 5'b01100);
    // Full FIFO: 5th FE read blocked, BE write still issues, one response unblocks.
    for (int k = 0; k < 4; k++)
      add($sformatf("full_rd%0d", k), 0, 1,0,8'h30 + 8'(k), 0,0,8'h00, 1, 0,32'h0,
          1,0,8'h30 + 8'(k), 5'b10000);
    add("full_be_wr", 0, 1,0,8'h34, 1,1,8'h94, 1, 0,32'h0, 1,1,8'h94, 5'b01000);
    add("full_blocked", 0, 1,0,8'h34, 0,0,8'h00, 1, 1,32'hF000_0001, 0,0,8'h00, 5'b00100);
    add("full_unblk", 0, 1,0,8'h34, 0,0,8'h00, 1, 0,32'h0, 1,0,8'h34, 5'b10000);
    for (int k = 0; k < 4; k++)
      add($sformatf("full_drain%0d", k), 0, 0,0,8'h00, 0,0,8'h00, 1, 1,32'hF000_0010 + k,
          0,0,8'h00, 5'b00100);
    // Interleaved FE,BE,BE,FE reads with responses two cycles behind.
    add("ilv_fe0", 0, 1,0,8'h40, 0,0,8'h00, 1, 0,32'h0, 1,0,8'h40, 5'b10000);
    add("ilv_be0", 0, 0,0,8'h00, 1,0,8'hA0, 1, 0,32'h0, 1,0,8'hA0, 5'b01000);
    add("ilv_be1", 0, 0,0,8'h00, 1,0,8'hA1, 1, 1,32'h1111_1111, 1,0,8'hA1, 5'b01100);
    add("ilv_fe1", 0, 1,0,8'h41, 0,0,8'h00, 1, 1,32'h2222_2222, 1,0,8'h41, 5'b10010);
    add("ilv_rsp3", 0, 0,0,8'h00, 0,0,8'h00, 1, 1,32'h3333_3333, 0,0,8'h00, 5'b00010);
    add("ilv_rsp4", 0, 0,0,8'h00, 0,0,8'h00, 1, 1,32'h4444_4444, 0,0,8'h00, 5'b00100);
    // Response with nothing outstanding.
    add("err_rsp", 0, 0,0,8'h00, 0,0,8'h00, 1, 1,32'hDEAD_BEEF, 0,0,8'h00, 5'b00000);
    add("err_set", 0, 0,0,8'h00, 0,0,8'h00, 1, 0,32'h0, 0,0,8'h00, 5'b00001);
    add("err_sticky", 0, 1,0,8'h50, 0,0,8'h00, 1, 0,32'h0, 1,0,8'h50, 5'b10001);

    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_src = SRC_FE;
    drive(1'b1, 0,0,8'h00, 0,0,8'h00, 0, 0,32'h0);
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].fv, vecs[i].fw, vecs[i].frow, vecs[i].bv, vecs[i].bw,
            vecs[i].brow, vecs[i].srdy, vecs[i].rv, vecs[i].rd);
      #1;
      got = {13'b0, sram_req_valid,
             sram_req_valid ? sram_req_row   : 8'h00,
             sram_req_valid ? sram_req_mask  : 4'h0,
             sram_req_valid ? sram_req_wdata : 32'h0,
             sram_req_valid ? sram_req_write : 1'b0,
             fe_req_ready, be_req_ready, fe_rsp_valid, be_rsp_valid, rsp_err};
      exp = {13'b0, vecs[i].esv,
             vecs[i].esv ? vecs[i].erow                : 8'h00,
             vecs[i].esv ? (vecs[i].erow[3:0] ^ 4'hF)  : 4'h0,
             vecs[i].esv ? {4{vecs[i].erow}}           : 32'h0,
             vecs[i].esv ? vecs[i].ewr                 : 1'b0,
             vecs[i].ef};
      chk(vecs[i].tag, got, exp);
      if (vecs[i].ef[2] || vecs[i].ef[1])
        chk({vecs[i].tag, "_rdata"}, {fe_rsp_rdata, be_rsp_rdata}, {vecs[i].rd, vecs[i].rd});
    end

    // Reset with two reads in flight: late responses flag an error, no strobes.
    idle_cycle(1'b1, 1'b0, 32'h0);
    idle_cycle(1'b0, 1'b0, 32'h0);
    chk("rst_clears_err", {63'b0, rsp_err}, 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1,0,8'h60 + 8'(k), 0,0,8'h00, 1, 0,32'h0);
      #1;
      chk($sformatf("inflight_rd%0d", k), {62'b0, sram_req_valid, fe_req_ready}, 64'h3);
    end
    @(negedge clk);
    drive(1'b1, 1,0,8'h62, 1,1,8'h92, 1, 0,32'h0);
    #1;
    chk("rst_outputs_low", {61'b0, sram_req_valid, fe_req_ready, be_req_ready}, 64'h0);
    for (int k = 0; k < 2; k++) begin
      idle_cycle(1'b0, 1'b1, 32'hCAFE_0000 + k);
      chk($sformatf("late_rsp%0d_strobe", k), {62'b0, fe_rsp_valid, be_rsp_valid}, 64'h0);
    end
    idle_cycle(1'b0, 1'b0, 32'h0);
    chk("late_rsp_err", {63'b0, rsp_err}, 64'h1);

    // Source FIFO alone: simultaneous push and pop while full.
    @(negedge clk); f_rst = 1'b1;
    @(negedge clk); f_rst = 1'b0; #1;
    chk("fifo_reset", {60'b0, f_empty, f_count}, {60'b0, 1'b1, 3'd0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); f_push = 1'b1; f_src = (k % 2 == 0) ? SRC_FE : SRC_BE;
    end
    @(negedge clk); f_push = 1'b0; #1;
    chk("fifo_full", {59'b0, f_full, f_head, f_count}, {59'b0, 1'b1, SRC_FE, 3'd4});
    @(negedge clk); f_push = 1'b1; f_src = SRC_BE; f_pop = 1'b1; #1;
    chk("fifo_pp_head", {63'b0, f_head}, {63'b0, SRC_FE});
    @(negedge clk); f_push = 1'b0; f_pop = 1'b0; #1;
    chk("fifo_pp_count", {59'b0, f_full, f_head, f_count}, {59'b0, 1'b1, SRC_BE, 3'd4});
    pop_exp[0] = SRC_BE; pop_exp[1] = SRC_FE; pop_exp[2] = SRC_BE; pop_exp[3] = SRC_BE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); f_pop = 1'b1; #1;
      chk($sformatf("fifo_pop%0d", k), {63'b0, f_head}, {63'b0, pop_exp[k]});
    end
    @(negedge clk); f_pop = 1'b0; #1;
    chk("fifo_drained", {60'b0, f_empty, f_count}, {60'b0, 1'b1, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
